// File: rtl/rf_pack.sv
// Shared types and fixed register indices for the register file / return stack.
package rf_pack;

    typedef enum logic [3:0] {
        NOP,
        MOV,
        INC,
        DEC,
        LDI_LO,
        LDI_HI,
        SETB,
        FLIP,
        SHL_CAT,
        SHR_CAT,
        CALL,
        RET
    } rf_op_t;

    localparam int unsigned M_IDX = 4;
    localparam int unsigned N_IDX = 5;
    localparam int unsigned V_IDX = 13;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack with sticky overflow/underflow flag.
// Overflowing pushes and underflowing pops leave the contents untouched.
module ret_stack #(
    parameter int unsigned AW        = 10,
    parameter int unsigned STK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          err
);

    localparam int unsigned CW = $clog2(STK_DEPTH + 1);
    localparam int unsigned IW = $clog2(STK_DEPTH);

    logic [AW-1:0] r_mem [STK_DEPTH];
    logic [CW-1:0] r_count;
    logic          r_err;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(STK_DEPTH));
    assign top   = empty ? '0 : r_mem[IW'(r_count - CW'(1))];
    assign err   = r_err;

    // r_count doubles as the write pointer; the top entry sits at r_count-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(STK_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            if (full) begin
                r_err <= 1'b1;
            end else begin
                r_mem[IW'(r_count)] <= push_data;
                r_count             <= r_count + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                r_err <= 1'b1;
            end else begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_file_stack.sv
// Special-purpose register file with bit/shift ops and a nested-call return stack.
// Reads are combinational and see the pre-write value in the write cycle.
module reg_file_stack
    import rf_pack::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned NREG      = 16,
    parameter int unsigned AW        = 10,
    parameter int unsigned STK_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  rf_op_t                  op,
    input  logic [$clog2(NREG)-1:0] src,
    input  logic [$clog2(NREG)-1:0] dst,
    input  logic [3:0]              imm,
    input  logic                    load_en,
    input  logic [DW-1:0]           load_data,
    input  logic                    stor_en,
    output logic [DW-1:0]           stor_data,
    output logic [DW-1:0]           rd_src,
    output logic                    src_zero,
    output logic                    res_zero,
    input  logic [AW-1:0]           pc_in,
    output logic [AW-1:0]           ret_addr,
    output logic                    stk_empty,
    output logic                    stk_full,
    output logic                    stk_err
);

    localparam int unsigned SW    = $clog2(NREG);
    localparam int unsigned NSLOT = 1 << SW;

    // Slots at or above NREG are never written, so they read back as 0.
    logic [DW-1:0] r_regs [NSLOT];

    logic [DW-1:0] w_src_val;
    logic [DW-1:0] w_incdec;
    logic [DW-1:0] w_tgt;
    logic [DW-1:0] w_oth;
    logic [DW-1:0] w_cat_l;
    logic [DW-1:0] w_cat_r;
    logic [DW-1:0] w_bit;
    logic [SW-1:0] w_tgt_idx;
    logic [SW-1:0] w_oth_idx;
    logic [2:0]    w_k;
    logic          w_wr_en;
    logic [SW-1:0] w_wr_idx;
    logic [DW-1:0] w_wr_data;
    logic          w_idx_ok;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_push_data;

    assign w_src_val = r_regs[src];
    assign w_incdec  = (op == DEC) ? w_src_val - DW'(1) : w_src_val + DW'(1);

    // imm[3] picks M or N as target; the other one feeds the shift-in bits.
    assign w_tgt_idx = imm[3] ? SW'(N_IDX) : SW'(M_IDX);
    assign w_oth_idx = imm[3] ? SW'(M_IDX) : SW'(N_IDX);
    assign w_tgt     = r_regs[w_tgt_idx];
    assign w_oth     = r_regs[w_oth_idx];
    assign w_k       = imm[2:0];
    assign w_bit     = DW'(1) << w_k;
    assign w_cat_l   = (w_k == 3'd0) ? w_oth
                                     : (w_tgt << w_k) | (w_oth >> (DW - 32'(w_k)));
    assign w_cat_r   = (w_k == 3'd0) ? w_oth
                                     : (w_tgt >> w_k) | (w_oth << (DW - 32'(w_k)));

    // Single write port; a memory load takes it over from the op.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = dst;
        w_wr_data = '0;
        if (load_en) begin
            w_wr_en   = 1'b1;
            w_wr_data = load_data;
        end else begin
            case (op)
                MOV: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = (src == dst) ? '0 : w_src_val;
                end
                INC, DEC: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_incdec;
                end
                LDI_LO: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = SW'(V_IDX);
                    w_wr_data = (r_regs[SW'(V_IDX)] & ~DW'(8'h0F)) | DW'(imm);
                end
                LDI_HI: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = SW'(V_IDX);
                    w_wr_data = (r_regs[SW'(V_IDX)] & ~DW'(8'hF0)) | (DW'(imm) << 4);
                end
                SETB: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_tgt_idx;
                    w_wr_data = w_tgt | w_bit;
                end
                FLIP: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_tgt_idx;
                    w_wr_data = w_tgt ^ w_bit;
                end
                SHL_CAT: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_tgt_idx;
                    w_wr_data = w_cat_l;
                end
                SHR_CAT: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_tgt_idx;
                    w_wr_data = w_cat_r;
                end
                default: ;
            endcase
        end
    end

    if (NREG == NSLOT) begin : g_full_decode
        assign w_idx_ok = 1'b1;
    end else begin : g_part_decode
        assign w_idx_ok = (32'(w_wr_idx) < NREG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en && w_idx_ok) begin
            r_regs[w_wr_idx] <= w_wr_data;
        end
    end

    assign rd_src    = w_src_val;
    assign src_zero  = (w_src_val == '0);
    assign stor_data = stor_en ? w_src_val : '0;
    assign res_zero  = ((op == INC) || (op == DEC)) && !load_en && w_idx_ok
                       && (w_incdec == '0);

    assign w_push      = (op == CALL);
    assign w_pop       = (op == RET);
    assign w_push_data = pc_in + AW'(1);

    ret_stack #(
        .AW        (AW),
        .STK_DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .top       (ret_addr),
        .empty     (stk_empty),
        .full      (stk_full),
        .err       (stk_err)
    );

endmodule

// File: tb/tb_reg_file_stack.sv
// Bench for reg_file_stack: directed vector table, then random ops against
// an array/queue reference model of registers and return stack.
module tb_reg_file_stack;
    import rf_pack::*;

    localparam int unsigned DW        = 8;
    localparam int unsigned NREG      = 16;
    localparam int unsigned AW        = 10;
    localparam int unsigned STK_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    rf_op_t        op;
    logic [3:0]    src;
    logic [3:0]    dst;
    logic [3:0]    imm;
    logic          load_en;
    logic [DW-1:0] load_data;
    logic          stor_en;
    logic [DW-1:0] stor_data;
    logic [DW-1:0] rd_src;
    logic          src_zero;
    logic          res_zero;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] ret_addr;
    logic          stk_empty;
    logic          stk_full;
    logic          stk_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_stack #(
        .DW        (DW),
        .NREG      (NREG),
        .AW        (AW),
        .STK_DEPTH (STK_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .src       (src),
        .dst       (dst),
        .imm       (imm),
        .load_en   (load_en),
        .load_data (load_data),
        .stor_en   (stor_en),
        .stor_data (stor_data),
        .rd_src    (rd_src),
        .src_zero  (src_zero),
        .res_zero  (res_zero),
        .pc_in     (pc_in),
        .ret_addr  (ret_addr),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err)
    );

    typedef struct {
        logic       rst;
        rf_op_t     op;
        logic [3:0] src;
        logic [3:0] dst;
        logic [3:0] imm;
        logic       ld;
        logic [7:0] ldd;
        logic       st;
        logic [9:0] pc;
        logic [7:0] e_rd;
        logic       e_rz;
        logic [9:0] e_ret;
        logic       e_emp;
        logic       e_full;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int m_r [16];
    int stk[$];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input rf_op_t o, input logic [3:0] s, input logic [3:0] d,
                         input logic [3:0] i, input logic le, input logic [7:0] ld,
                         input logic se, input logic [9:0] pc);
        rst_n     = r;
        op        = o;
        src       = s;
        dst       = d;
        imm       = i;
        load_en   = le;
        load_data = ld;
        stor_en   = se;
        pc_in     = pc;
    endtask

    // Register-path row: stack expected to be in its reset state.
    function automatic vec_t reg_row(rf_op_t o, int s, int d, int i, bit ld, int ldd, bit st,
                                     int erd, bit erz);
        vec_t x;
        x.rst = 1'b1; x.op = o; x.src = 4'(s); x.dst = 4'(d); x.imm = 4'(i);
        x.ld = ld; x.ldd = 8'(ldd); x.st = st; x.pc = '0;
        x.e_rd = 8'(erd); x.e_rz = erz; x.e_ret = '0;
        x.e_emp = 1'b1; x.e_full = 1'b0; x.e_err = 1'b0;
        return x;
    endfunction

    // Stack-path row: reads R0, which is never written.
    function automatic vec_t stk_row(bit r, rf_op_t o, int pc, int eret, bit emp, bit full, bit err);
        vec_t x;
        x.rst = r; x.op = o; x.src = '0; x.dst = '0; x.imm = '0;
        x.ld = 1'b0; x.ldd = '0; x.st = 1'b0; x.pc = 10'(pc);
        x.e_rd = '0; x.e_rz = 1'b0; x.e_ret = 10'(eret);
        x.e_emp = emp; x.e_full = full; x.e_err = err;
        return x;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 16; j++) m_r[j] = 0;
        stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(bit r, rf_op_t o, int s, int d, int i, bit le, int ldd, int pc);
        int t;
        int ot;
        int k;
        if (!r) begin
            model_reset();
            return;
        end
        t  = ((i & 8) != 0) ? 5 : 4;
        ot = 9 - t;
        k  = i & 7;
        if (o == CALL) begin
            if (stk.size() == 4) m_err = 1'b1;
            else stk.push_back((pc + 1) % 1024);
        end else if (o == RET) begin
            if (stk.size() == 0) m_err = 1'b1;
            else void'(stk.pop_back());
        end
        if (le) begin
            m_r[d] = ldd;
            return;
        end
        case (o)
            MOV:     m_r[d] = (s == d) ? 0 : m_r[s];
            INC:     m_r[d] = (m_r[s] + 1) % 256;
            DEC:     m_r[d] = (m_r[s] + 255) % 256;
            LDI_LO:  m_r[13] = (m_r[13] & 'hF0) | i;
            LDI_HI:  m_r[13] = (m_r[13] & 'h0F) | (i * 16);
            SETB:    m_r[t] = m_r[t] | (1 << k);
            FLIP:    m_r[t] = m_r[t] ^ (1 << k);
            SHL_CAT: m_r[t] = (k == 0) ? m_r[ot] : (((m_r[t] * 256 + m_r[ot]) << k) >> 8) & 255;
            SHR_CAT: m_r[t] = (k == 0) ? m_r[ot] : ((m_r[ot] * 256 + m_r[t]) >> k) & 255;
            default: ;
        endcase
    endtask

    initial begin
        drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0, 10'd0);
        repeat (2) @(posedge clk);

        // Register path
        vecs.push_back(reg_row(NOP,     0, 0, 0,  0, 0,    0, 8'h00, 0));
        vecs.push_back(reg_row(NOP,     2, 2, 0,  1, 'h5A, 0, 8'h00, 0));
        vecs.push_back(reg_row(MOV,     2, 2, 0,  0, 0,    0, 8'h5A, 0));
        vecs.push_back(reg_row(NOP,     2, 0, 0,  0, 0,    0, 8'h00, 0));
        vecs.push_back(reg_row(INC,     6, 6, 0,  1, 'h33, 0, 8'h00, 0));
        vecs.push_back(reg_row(NOP,     6, 0, 0,  0, 0,    0, 8'h33, 0));
        vecs.push_back(reg_row(NOP,     7, 7, 0,  1, 'hFF, 0, 8'h00, 0));
        vecs.push_back(reg_row(INC,     7, 7, 0,  0, 0,    0, 8'hFF, 1));
        vecs.push_back(reg_row(DEC,     7, 7, 0,  0, 0,    0, 8'h00, 0));
        vecs.push_back(reg_row(NOP,     7, 0, 0,  0, 0,    1, 8'hFF, 0));
        vecs.push_back(reg_row(NOP,     4, 4, 0,  1, 'hA5, 0, 8'h00, 0));
        vecs.push_back(reg_row(NOP,     4, 5, 0,  1, 'h3C, 0, 8'hA5, 0));
        vecs.push_back(reg_row(SHL_CAT, 4, 0, 3,  0, 0,    0, 8'hA5, 0));
        vecs.push_back(reg_row(SHR_CAT, 4, 0, 8,  0, 0,    0, 8'h29, 0));
        vecs.push_back(reg_row(NOP,     5, 0, 0,  0, 0,    0, 8'h29, 0));
        vecs.push_back(reg_row(LDI_LO, 13, 0, 7,  0, 0,    0, 8'h00, 0));
        vecs.push_back(reg_row(LDI_HI, 13, 0, 12, 0, 0,    0, 8'h07, 0));
        vecs.push_back(reg_row(SETB,   13, 0, 7,  0, 0,    0, 8'hC7, 0));
        vecs.push_back(reg_row(FLIP,    4, 0, 8,  0, 0,    0, 8'hA9, 0));
        vecs.push_back(reg_row(NOP,     5, 0, 0,  0, 0,    1, 8'h28, 0));
        // Return stack: fill, overflow, drain, underflow, wrap, reset
        vecs.push_back(stk_row(1, CALL, 10,   0,  1, 0, 0));
        vecs.push_back(stk_row(1, CALL, 20,   11, 0, 0, 0));
        vecs.push_back(stk_row(1, CALL, 30,   21, 0, 0, 0));
        vecs.push_back(stk_row(1, CALL, 40,   31, 0, 0, 0));
        vecs.push_back(stk_row(1, CALL, 50,   41, 0, 1, 0));
        vecs.push_back(stk_row(1, RET,  0,    41, 0, 1, 1));
        vecs.push_back(stk_row(1, RET,  0,    31, 0, 0, 1));
        vecs.push_back(stk_row(1, RET,  0,    21, 0, 0, 1));
        vecs.push_back(stk_row(1, RET,  0,    11, 0, 0, 1));
        vecs.push_back(stk_row(1, RET,  0,    0,  1, 0, 1));
        vecs.push_back(stk_row(1, NOP,  0,    0,  1, 0, 1));
        vecs.push_back(stk_row(1, CALL, 1023, 0,  1, 0, 1));
        vecs.push_back(stk_row(0, NOP,  0,    0,  0, 0, 1));
        vecs.push_back(stk_row(1, NOP,  0,    0,  1, 0, 0));
        vecs.push_back(reg_row(NOP,     5, 0, 0,  0, 0,    1, 8'h00, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            drive(vecs[n].rst, vecs[n].op, vecs[n].src, vecs[n].dst, vecs[n].imm,
                  vecs[n].ld, vecs[n].ldd, vecs[n].st, vecs[n].pc);
            #1;
            chk($sformatf("v%0d.rd_src", n),    32'(rd_src),    32'(vecs[n].e_rd));
            chk($sformatf("v%0d.src_zero", n),  32'(src_zero),  32'(vecs[n].e_rd == 8'h00));
            chk($sformatf("v%0d.stor_data", n), 32'(stor_data), vecs[n].st ? 32'(vecs[n].e_rd) : 32'd0);
            chk($sformatf("v%0d.res_zero", n),  32'(res_zero),  32'(vecs[n].e_rz));
            chk($sformatf("v%0d.ret_addr", n),  32'(ret_addr),  32'(vecs[n].e_ret));
            chk($sformatf("v%0d.stk_empty", n), 32'(stk_empty), 32'(vecs[n].e_emp));
            chk($sformatf("v%0d.stk_full", n),  32'(stk_full),  32'(vecs[n].e_full));
            chk($sformatf("v%0d.stk_err", n),   32'(stk_err),   32'(vecs[n].e_err));
        end

        // Random phase against the reference model
        @(negedge clk);
        drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0, 10'd0);
        model_reset();
        for (int n = 0; n < 800; n++) begin
            bit     r;
            rf_op_t o;
            int     s, d, i, ldd, pc, nv;
            bit     le, se, erz;
            @(negedge clk);
            r   = ($urandom_range(0, 99) != 0);
            o   = rf_op_t'(4'($urandom_range(0, 11)));
            s   = $urandom_range(0, 15);
            d   = ($urandom_range(0, 3) == 0) ? s : $urandom_range(0, 15);
            i   = $urandom_range(0, 15);
            le  = ($urandom_range(0, 4) == 0);
            ldd = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            se  = $urandom_range(0, 1);
            pc  = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023);
            drive(r, o, 4'(s), 4'(d), 4'(i), le, 8'(ldd), se, 10'(pc));
            #1;
            nv  = (o == INC) ? (m_r[s] + 1) % 256 : (m_r[s] + 255) % 256;
            erz = ((o == INC) || (o == DEC)) && !le && (nv == 0);
            chk($sformatf("r%0d.rd_src", n),    32'(rd_src),    32'(m_r[s]));
            chk($sformatf("r%0d.src_zero", n),  32'(src_zero),  32'(m_r[s] == 0));
            chk($sformatf("r%0d.stor_data", n), 32'(stor_data), se ? 32'(m_r[s]) : 32'd0);
            chk($sformatf("r%0d.res_zero", n),  32'(res_zero),  32'(erz));
            chk($sformatf("r%0d.ret_addr", n),  32'(ret_addr),  (stk.size() != 0) ? 32'(stk[$]) : 32'd0);
            chk($sformatf("r%0d.stk_empty", n), 32'(stk_empty), 32'(stk.size() == 0));
            chk($sformatf("r%0d.stk_full", n),  32'(stk_full),  32'(stk.size() == int'(STK_DEPTH)));
            chk($sformatf("r%0d.stk_err", n),   32'(stk_err),   32'(m_err));
            model_step(r, o, s, d, i, le, ldd, pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_stack.md
Name: reg_file_stack

Overview:
- Parametrised successor to the CPU's special-purpose register file: NREG general registers of DW bits, addressed by src/dst fields from the decoder.
- Adds a hardware return-address stack of configurable depth, replacing the single link register; this enables nested subroutine calls.
- Sits between decode (op/src/dst/imm), the data-memory port (load/store) and the program counter (pc_in in, ret_addr out).
- All register state is synchronous to clk.

Parameters:
- DW, 8: register data width; must be >= 8.
- NREG, 16: number of registers; must be >= 16.
- AW, 10: instruction-address width for the call stack.
- STK_DEPTH, 4: number of return-stack entries; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- op  in  rf_op_t  register operation from decode.
- src  in  $clog2(NREG)  source register index.
- dst  in  $clog2(NREG)  destination register index.
- imm  in  4  immediate / bit-select field.
- load_en  in  1  write load_data into R[dst] this cycle.
- load_data  in  DW  data-memory read data.
- stor_en  in  1  drive stor_data.
- stor_data  out  DW  R[src] when stor_en, else 0; never tristate.
- rd_src  out  DW  combinational R[src].
- src_zero  out  1  combinational (R[src] == 0).
- res_zero  out  1  combinational; 1 when op is INC/DEC and the result written to dst is 0, else 0.
- pc_in  in  AW  address of the current instruction.
- ret_addr  out  AW  top-of-stack entry; 0 when the stack is empty.
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds STK_DEPTH entries.
- stk_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: when rst_n=0 at posedge clk, all registers, stack entries, stack count and stk_err go to 0. Outputs follow: rd_src=0, src_zero=1, ret_addr=0, stk_empty=1, stk_full=0.
- Register-write priority: load_en over op. When load_en=1, R[dst] <= load_data and the op's register write is suppressed. The op's stack action still happens.
- Register-write ops, all updating on posedge clk with 1-cycle latency:
  - NOP: no write.
  - MOV: R[dst] <= R[src]. When src==dst, R[dst] <= 0 (clear idiom).
  - INC/DEC: R[dst] <= R[src] ± 1, modulo 2^DW (wraps).
  - LDI_LO: R[V_IDX][3:0] <= imm. LDI_HI: R[V_IDX][7:4] <= imm. Other bits are unchanged.
  - SETB: imm[3] selects target T (0 = M_IDX, 1 = N_IDX); T[imm[2:0]] <= 1.
  - FLIP: same target selection; T[imm[2:0]] toggles.
  - SHL_CAT: T selected by imm[3], O is the other pair register, k = imm[2:0]. T <= (T << k) | (O >> (DW-k)). k=0 gives T <= O.
  - SHR_CAT: same selection. T <= (T >> k) | (O << (DW-k)). k=0 gives T <= O.
- Stack ops:
  - CALL: push (pc_in+1) mod 2^AW. When full, the push is dropped, contents are unchanged and stk_err <= 1.
  - RET: pop. When empty, no change, ret_addr stays 0 and stk_err <= 1.
- ret_addr is combinational from the current top entry. The decoder samples it in the RET cycle, before the pop takes effect.
- stk_err is cleared only by reset.
- Store path is purely combinational. Reading a register in the same cycle it is written returns the old value; there is no write-through.
- Out-of-range dst (>= NREG, only possible when NREG is not a power of 2) causes no write. Out-of-range src reads 0.

Decomposition:
- Package rf_pack holds:
  - enum rf_op_t {NOP, MOV, INC, DEC, LDI_LO, LDI_HI, SETB, FLIP, SHL_CAT, SHR_CAT, CALL, RET};
  - localparams M_IDX=4, N_IDX=5, V_IDX=13.
- One sub-module, ret_stack (parameters AW, STK_DEPTH): push, pop, top, empty, full, err, with synchronous active-low reset.

Test Plan:
- Reset, then MOV src=dst=2 with R2 preloaded via load 0x5A → R2 = 0x00 the next cycle; src_zero=1 when src=2.
- load_en=1, load_data=0x33, dst=6, with op=INC src=6 in the same cycle → R6 = 0x33 (load wins).
- R7 = 0xFF, op=INC src=dst=7 → R7 = 0x00 and res_zero=1 during that cycle. Then DEC → R7 = 0xFF, res_zero=0.
- M = 0xA5, N = 0x3C, SHL_CAT imm=4'b0011 → M = 0x29. Then SHR_CAT imm=4'b1000 → N = 0x29.
- With STK_DEPTH=4:
  - CALL ×5 with pc_in = 10, 20, 30, 40, 50 → stk_full=1, stk_err=1, ret_addr = 41.
  - RET ×4 → ret_addr sequence 41, 31, 21, 11, then stk_empty=1.
  - A 5th RET keeps ret_addr=0 and stk_err=1.
- With pc_in = 2^AW−1, CALL → stored ret_addr = 0 (wrap). Then assert rst_n=0 mid-sequence → stack empty and stk_err=0 the next cycle.
